// File: rtl/tf530_autoconfig.sv
// Zorro II AUTOCONFIG responder and fast-RAM address decoder for the TF530.
// Presents one memory board at $E80000, accepts its base address, then
// decodes the assigned RAM range and acknowledges claimed cycles with DSACK1.
module tf530_autoconfig #(
  parameter logic [7:0]  PRODUCT      = 8'h01,
  parameter logic [15:0] MANUFACTURER = 16'h082C,
  parameter logic [31:0] SERIAL       = 32'h00000530,
  parameter logic [2:0]  SIZE_CODE    = 3'b000,
  parameter int unsigned WAIT_CLKS    = 2
) (
  input  logic        CLKCPU,
  input  logic        RESET,
  input  logic [2:0]  FC,
  input  logic [23:1] A,
  input  logic        AS20,
  input  logic        DS20,
  input  logic        RW20,
  input  logic [3:0]  DIN,
  output logic [3:0]  DOUT,
  output logic        DOE,
  output logic        DSACK1,
  output logic        INTSIG,
  output logic        RAMCS,
  output logic        CONFIGURED
);

  typedef enum logic [1:0] {CFG_UNCONF, CFG_CONF, CFG_SHUTUP} cfg_state_e;
  typedef enum logic [1:0] {CYC_IDLE, CYC_WAIT, CYC_ACK} cyc_state_e;

  cfg_state_e cfg_q, cfg_d;
  cyc_state_e cyc_q, cyc_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] base_q, base_d;
  logic [3:0] base_lo_q, base_lo_d;

  logic       cpu_space;
  logic       cfg_hit;
  logic       ram_match;
  logic       ram_hit;
  logic [3:0] cfg_nibble;
  logic       unused_ok;

  // Address decode: config window while unconfigured, base-relative RAM range once configured.
  always_comb begin
    cpu_space = (FC == 3'b111);
    case (SIZE_CODE)
      3'b110:  ram_match = (A[23:21] == base_q[3:1]);
      3'b111:  ram_match = (A[23:22] == base_q[3:2]);
      default: ram_match = (A[23] == base_q[3]);
    endcase
    cfg_hit = (cfg_q == CFG_UNCONF) & ~cpu_space & (A[23:16] == 8'hE8);
    ram_hit = (cfg_q == CFG_CONF) & ~cpu_space & ram_match;
  end

  // AUTOCONFIG ROM: er_Type and $40/$42 read true, everything else reads inverted.
  always_comb begin
    cfg_nibble = '1;
    case (A[6:1])
      6'h00:        cfg_nibble = 4'hE;
      6'h01:        cfg_nibble = {1'b0, SIZE_CODE};
      6'h02:        cfg_nibble = ~PRODUCT[7:4];
      6'h03:        cfg_nibble = ~PRODUCT[3:0];
      6'h04, 6'h05: cfg_nibble = '1;
      6'h08:        cfg_nibble = ~MANUFACTURER[15:12];
      6'h09:        cfg_nibble = ~MANUFACTURER[11:8];
      6'h0A:        cfg_nibble = ~MANUFACTURER[7:4];
      6'h0B:        cfg_nibble = ~MANUFACTURER[3:0];
      6'h0C:        cfg_nibble = ~SERIAL[31:28];
      6'h0D:        cfg_nibble = ~SERIAL[27:24];
      6'h0E:        cfg_nibble = ~SERIAL[23:20];
      6'h0F:        cfg_nibble = ~SERIAL[19:16];
      6'h10:        cfg_nibble = ~SERIAL[15:12];
      6'h11:        cfg_nibble = ~SERIAL[11:8];
      6'h12:        cfg_nibble = ~SERIAL[7:4];
      6'h13:        cfg_nibble = ~SERIAL[3:0];
      6'h20, 6'h21: cfg_nibble = '0;
      default:      cfg_nibble = '1;
    endcase
  end

  // Cycle FSM next state; config writes commit on the edge that enters ACK.
  always_comb begin
    cyc_d     = cyc_q;
    cnt_d     = cnt_q;
    cfg_d     = cfg_q;
    base_d    = base_q;
    base_lo_d = base_lo_q;
    case (cyc_q)
      CYC_IDLE: begin
        if (~AS20 && (cfg_hit || ram_hit)) begin
          cyc_d = CYC_WAIT;
          cnt_d = 3'(WAIT_CLKS - 1);
        end
      end
      CYC_WAIT: begin
        if (AS20) begin
          cyc_d = CYC_IDLE;
        end else if (cnt_q == '0) begin
          cyc_d = CYC_ACK;
          if (cfg_hit && !RW20 && !DS20) begin
            case (A[6:1])
              6'h24: begin
                base_d = DIN;
                cfg_d  = CFG_CONF;
              end
              6'h25:   base_lo_d = DIN;
              6'h26:   cfg_d     = CFG_SHUTUP;
              default: ;
            endcase
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      CYC_ACK: begin
        if (AS20) cyc_d = CYC_IDLE;
      end
      default: cyc_d = CYC_IDLE;
    endcase
  end

  // State registers; reset discards configuration and any cycle in flight.
  always_ff @(posedge CLKCPU or posedge RESET) begin
    if (RESET) begin
      cyc_q     <= CYC_IDLE;
      cfg_q     <= CFG_UNCONF;
      cnt_q     <= '0;
      base_q    <= '0;
      base_lo_q <= '0;
    end else begin
      cyc_q     <= cyc_d;
      cfg_q     <= cfg_d;
      cnt_q     <= cnt_d;
      base_q    <= base_d;
      base_lo_q <= base_lo_d;
    end
  end

  // Bus outputs; the combinational strobes are forced inactive while RESET is high.
  always_comb begin
    INTSIG     = ~((cfg_hit | ram_hit) & ~AS20 & ~RESET);
    RAMCS      = ~(ram_hit & ~AS20 & ~RESET);
    DOE        = cfg_hit & RW20 & ~AS20 & ~RESET;
    DOUT       = DOE ? cfg_nibble : 4'hF;
    DSACK1     = ~(cyc_q == CYC_ACK);
    CONFIGURED = (cfg_q == CFG_CONF);
  end

  assign unused_ok = &{1'b0, A[15:7], base_q, base_lo_q};

endmodule

// File: tb/tb_tf530_autoconfig.sv
// Self-checking bench for tf530_autoconfig: directed vector table, corner
// sequences, then randomized bus cycles against a Zorro-level reference model.
module tb_tf530_autoconfig;

  localparam int unsigned W    = 2;
  localparam logic [2:0]  SIZE = 3'b000;
  localparam logic [7:0]  PROD = 8'h01;
  localparam logic [15:0] MANF = 16'h082C;
  localparam logic [31:0] SERN = 32'h00000530;

  logic        CLKCPU = 1'b0;
  logic        RESET  = 1'b1;
  logic [2:0]  FC     = 3'd5;
  logic [23:1] A      = '0;
  logic        AS20   = 1'b1;
  logic        DS20   = 1'b1;
  logic        RW20   = 1'b1;
  logic [3:0]  DIN    = '0;
  logic [3:0]  DOUT;
  logic        DOE, DSACK1, INTSIG, RAMCS, CONFIGURED;

  tf530_autoconfig #(
    .PRODUCT(PROD), .MANUFACTURER(MANF), .SERIAL(SERN),
    .SIZE_CODE(SIZE), .WAIT_CLKS(W)
  ) dut (
    .CLKCPU(CLKCPU), .RESET(RESET), .FC(FC), .A(A), .AS20(AS20), .DS20(DS20),
    .RW20(RW20), .DIN(DIN), .DOUT(DOUT), .DOE(DOE), .DSACK1(DSACK1),
    .INTSIG(INTSIG), .RAMCS(RAMCS), .CONFIGURED(CONFIGURED)
  );

  always #5 CLKCPU = ~CLKCPU;

  int tests  = 0;
  int failed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: ROM as the Zorro register map, board state as plain variables.
  logic [3:0] rom [64];
  int         m_cfg;   // 0 unconfigured, 1 configured, 2 shut up
  logic [3:0] m_base;

  task automatic put_byte(input int off, input logic [7:0] v);
    rom[off / 2]     = ~v[7:4];
    rom[off / 2 + 1] = ~v[3:0];
  endtask

  task automatic init_rom();
    for (int i = 0; i < 64; i++) rom[i] = 4'hF;
    rom[0] = 4'hE;
    rom[1] = {1'b0, SIZE};
    put_byte(8'h04, PROD);
    put_byte(8'h08, 8'h00);
    put_byte(8'h10, MANF[15:8]);
    put_byte(8'h14, MANF[7:0]);
    put_byte(8'h18, SERN[31:24]);
    put_byte(8'h1C, SERN[23:16]);
    put_byte(8'h20, SERN[15:8]);
    put_byte(8'h24, SERN[7:0]);
    rom[8'h40 / 2] = 4'h0;
    rom[8'h42 / 2] = 4'h0;
  endtask

  function automatic logic m_cfg_hit(input logic [2:0] fc, input logic [23:0] addr);
    return (m_cfg == 0) && (fc != 3'd7) && (addr[23:16] == 8'hE8);
  endfunction

  function automatic logic m_ram_hit(input logic [2:0] fc, input logic [23:0] addr);
    int unsigned n, a, b;
    n = (SIZE == 3'b110) ? 3 : (SIZE == 3'b111) ? 2 : 1;
    a = 32'(addr);
    b = 32'(m_base);
    return (m_cfg == 1) && (fc != 3'd7) && ((a >> (24 - n)) == (b >> (4 - n)));
  endfunction

  task automatic do_reset();
    @(negedge CLKCPU);
    RESET = 1'b1; AS20 = 1'b1; DS20 = 1'b1;
    @(negedge CLKCPU);
    RESET = 1'b0;
    m_cfg  = 0;
    m_base = '0;
  endtask

  // One bus cycle; checks strobes before the first edge and the DSACK1 edge count.
  task automatic run_cycle(input string tag, input logic [2:0] fc, input logic [23:0] addr,
                           input logic rw, input logic [3:0] din, input logic ds_low,
                           input logic abort, input logic e_intsig, input logic e_ramcs,
                           input logic e_doe, input logic [3:0] e_dout, input logic e_ack);
    int n;
    @(negedge CLKCPU);
    FC = fc; A = addr[23:1]; RW20 = rw; DIN = din; AS20 = 1'b0; DS20 = ~ds_low;
    #1;
    chk({tag, " INTSIG"}, INTSIG, e_intsig);
    chk({tag, " RAMCS"}, RAMCS, e_ramcs);
    chk({tag, " DOE"}, DOE, e_doe);
    if (e_doe) chk({tag, " DOUT"}, DOUT, e_dout);
    n = 0;
    if (abort) begin
      @(posedge CLKCPU); #1;
      if (DSACK1 == 1'b0) n = 1;
      @(negedge CLKCPU);
      AS20 = 1'b1; DS20 = 1'b1;
      for (int i = 0; i < int'(W) + 3; i++) begin
        @(posedge CLKCPU); #1;
        if (DSACK1 == 1'b0 && n == 0) n = i + 2;
      end
      chk({tag, " aborted DSACK1 edge"}, n, 0);
    end else begin
      for (int i = 1; i <= int'(W) + 4 && n == 0; i++) begin
        @(posedge CLKCPU); #1;
        if (DSACK1 == 1'b0) n = i;
      end
      chk({tag, " DSACK1 edge"}, n, e_ack ? W + 1 : 0);
      @(negedge CLKCPU);
      AS20 = 1'b1; DS20 = 1'b1;
      @(posedge CLKCPU); #1;
      chk({tag, " DSACK1 release"}, DSACK1, 1'b1);
    end
  endtask

  task automatic model_cycle(input logic [2:0] fc, input logic [23:0] addr, input logic rw,
                             input logic [3:0] din, input logic ds_low, input logic abort);
    logic ch, rh;
    ch = m_cfg_hit(fc, addr);
    rh = m_ram_hit(fc, addr);
    run_cycle("rnd", fc, addr, rw, din, ds_low, abort, !(ch || rh), !rh,
              ch && rw, rom[addr[6:1]], ch || rh);
    if (ch && !rw && ds_low && !abort) begin
      if (addr[7:0] == 8'h48) begin m_base = din; m_cfg = 1; end
      else if (addr[7:0] == 8'h4C) m_cfg = 2;
    end
    chk("rnd CONFIGURED", CONFIGURED, m_cfg == 1);
  endtask

  typedef struct {
    logic [2:0]  fc;
    logic [23:0] addr;
    logic        rw;
    logic [3:0]  din;
    logic        intsig, ramcs, doe;
    logic [3:0]  dout;
    logic        ack, conf;
  } vec_t;

  vec_t vecs [16];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [2:0]  fc;
    logic [23:0] addr;
    logic        rw, ds_low, abort;
    logic [3:0]  din;
    int          idx;

    init_rom();
    m_cfg  = 0;
    m_base = '0;
    //          fc     addr          rw    din   intsig ramcs doe   dout  ack   conf
    vecs = '{
      '{3'd5, 24'hE80000, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 4'hE, 1'b1, 1'b0},
      '{3'd5, 24'hE80002, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 4'h0, 1'b1, 1'b0},
      '{3'd5, 24'hE80010, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 4'hF, 1'b1, 1'b0},
      '{3'd5, 24'hE80012, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 4'h7, 1'b1, 1'b0},
      '{3'd5, 24'hE80014, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 4'hD, 1'b1, 1'b0},
      '{3'd5, 24'hE80016, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 4'h3, 1'b1, 1'b0},
      '{3'd5, 24'hE80030, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 4'hF, 1'b1, 1'b0},
      '{3'd5, 24'hE80040, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 4'h0, 1'b1, 1'b0},
      '{3'd5, 24'hE80006, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 4'hE, 1'b1, 1'b0},
      '{3'd7, 24'hE80000, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0},
      '{3'd5, 24'hE8004A, 1'b0, 4'h5, 1'b0, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0},
      '{3'd5, 24'hE80048, 1'b0, 4'h2, 1'b0, 1'b1, 1'b0, 4'hF, 1'b1, 1'b1},
      '{3'd5, 24'h200000, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 4'hF, 1'b1, 1'b1},
      '{3'd5, 24'hA00000, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 4'hF, 1'b0, 1'b1},
      '{3'd5, 24'hE80000, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 4'hF, 1'b0, 1'b1},
      '{3'd1, 24'h300000, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 4'hF, 1'b1, 1'b1}
    };

    // Reset state
    #12;
    chk("reset DSACK1", DSACK1, 1'b1);
    chk("reset INTSIG", INTSIG, 1'b1);
    chk("reset RAMCS", RAMCS, 1'b1);
    chk("reset DOE", DOE, 1'b0);
    chk("reset DOUT", DOUT, 4'hF);
    chk("reset CONFIGURED", CONFIGURED, 1'b0);
    @(negedge CLKCPU);
    RESET = 1'b0;

    // Directed vector table
    for (int i = 0; i < 16; i++) begin
      run_cycle($sformatf("vec%0d", i), vecs[i].fc, vecs[i].addr, vecs[i].rw, vecs[i].din,
                1'b1, 1'b0, vecs[i].intsig, vecs[i].ramcs, vecs[i].doe, vecs[i].dout,
                vecs[i].ack);
      chk($sformatf("vec%0d CONFIGURED", i), CONFIGURED, vecs[i].conf);
    end

    // Aborted config write: AS20 released one edge after falling
    do_reset();
    run_cycle("abort48", 3'd5, 24'hE80048, 1'b0, 4'h2, 1'b1, 1'b1,
              1'b0, 1'b1, 1'b0, 4'hF, 1'b0);
    chk("abort48 CONFIGURED", CONFIGURED, 1'b0);
    run_cycle("after abort", 3'd5, 24'hE80000, 1'b1, 4'h0, 1'b1, 1'b0,
              1'b0, 1'b1, 1'b1, 4'hE, 1'b1);

    // Write with DS20 high is acknowledged but not committed
    run_cycle("ds high 48", 3'd5, 24'hE80048, 1'b0, 4'h2, 1'b0, 1'b0,
              1'b0, 1'b1, 1'b0, 4'hF, 1'b1);
    chk("ds high CONFIGURED", CONFIGURED, 1'b0);

    // Shut-up: board disappears until reset
    run_cycle("shutup 4C", 3'd5, 24'hE8004C, 1'b0, 4'h0, 1'b1, 1'b0,
              1'b0, 1'b1, 1'b0, 4'hF, 1'b1);
    run_cycle("shutup E80000", 3'd5, 24'hE80000, 1'b1, 4'h0, 1'b1, 1'b0,
              1'b1, 1'b1, 1'b0, 4'hF, 1'b0);
    run_cycle("shutup 000000", 3'd5, 24'h000000, 1'b1, 4'h0, 1'b1, 1'b0,
              1'b1, 1'b1, 1'b0, 4'hF, 1'b0);
    run_cycle("shutup 48", 3'd5, 24'hE80048, 1'b0, 4'h0, 1'b1, 1'b0,
              1'b1, 1'b1, 1'b0, 4'hF, 1'b0);
    chk("shutup CONFIGURED", CONFIGURED, 1'b0);

    // Reset while a RAM cycle sits in ACK
    do_reset();
    run_cycle("cfg base0", 3'd5, 24'hE80048, 1'b0, 4'h0, 1'b1, 1'b0,
              1'b0, 1'b1, 1'b0, 4'hF, 1'b1);
    chk("cfg base0 CONFIGURED", CONFIGURED, 1'b1);
    @(negedge CLKCPU);
    FC = 3'd5; A = '0; RW20 = 1'b1; AS20 = 1'b0; DS20 = 1'b0;
    n = 0;
    for (int i = 1; i <= 10 && n == 0; i++) begin
      @(posedge CLKCPU); #1;
      if (DSACK1 == 1'b0) n = i;
    end
    chk("rst-in-ack DSACK1 edge", n, W + 1);
    #2 RESET = 1'b1;
    #1;
    chk("rst-in-ack DSACK1", DSACK1, 1'b1);
    chk("rst-in-ack CONFIGURED", CONFIGURED, 1'b0);
    chk("rst-in-ack INTSIG", INTSIG, 1'b1);
    chk("rst-in-ack RAMCS", RAMCS, 1'b1);
    @(negedge CLKCPU);
    AS20 = 1'b1; DS20 = 1'b1;
    @(negedge CLKCPU);
    RESET = 1'b0;
    m_cfg = 0; m_base = '0;
    run_cycle("post-reset E80000", 3'd5, 24'hE80000, 1'b1, 4'h0, 1'b1, 1'b0,
              1'b0, 1'b1, 1'b1, 4'hE, 1'b1);

    // Randomized cycles against the model
    do_reset();
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 99) < 3) begin
        do_reset();
        continue;
      end
      case ($urandom_range(0, 9))
        0:       fc = 3'd7;
        1, 2:    fc = 3'd1;
        3, 4:    fc = 3'd2;
        5:       fc = 3'd6;
        default: fc = 3'd5;
      endcase
      rw = 1'($urandom_range(0, 1));
      din = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) begin
        if (rw) begin
          idx = $urandom_range(0, 59);
          if (idx >= 16) idx += 4;
          addr = 24'hE80000 | 24'(idx * 2);
        end else begin
          case ($urandom_range(0, 5))
            0, 1:    addr = 24'hE80048;
            2:       addr = 24'hE8004A;
            3:       addr = 24'hE8004C;
            default: addr = 24'hE80000 | 24'(2 * $urandom_range(0, 63));
          endcase
        end
      end else begin
        addr = 24'($urandom) & 24'hFFFFFE;
      end
      ds_low = ($urandom_range(0, 9) != 0);
      abort  = ($urandom_range(0, 7) == 0);
      model_cycle(fc, addr, rw, din, ds_low, abort);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
